// File: rtl/value_feeder.sv
// Pacing stage ahead of the LED accumulator: buffers upstream words in a small FIFO
// and issues each one with a single enable pulse, holding value across the acceptance window.
module value_feeder #(
    parameter int DW   = 32,
    parameter int AW   = 2,
    parameter int HOLD = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic          enable,
    output logic [DW-1:0] value,
    output logic          busy,
    output logic [AW:0]   level
);

    localparam int          DEPTH     = 1 << AW;
    localparam logic [AW:0] LVL_ZERO  = (AW+1)'(0);
    localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [3:0]  HCNT_INIT = 4'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t          state_r;
    logic [3:0]      hcnt_r;
    logic            enable_r;
    logic            busy_r;
    logic [DW-1:0]   value_r;
    logic [AW:0]     level_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [DW-1:0]   mem_r [DEPTH];

    logic            full_s;
    logic            ready_s;
    logic            push_s;
    logic            pop_req_s;
    logic            pop_s;

    // Handshake and pop qualification; flush blocks both directions this cycle.
    always_comb begin
        full_s    = (level_r == LVL_FULL);
        ready_s   = RST && !flush && !full_s;
        push_s    = in_valid && ready_s;
        pop_req_s = 1'b0;
        if (state_r == ST_IDLE) begin
            pop_req_s = 1'b1;
        end else if ((state_r == ST_HOLD) && (hcnt_r == 4'd0)) begin
            pop_req_s = 1'b1;
        end else begin
            pop_req_s = 1'b0;
        end
        pop_s     = pop_req_s && (level_r != LVL_ZERO) && !flush;
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            level_r  <= LVL_ZERO;
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
        end else if (flush) begin
            level_r  <= LVL_ZERO;
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Issue FSM: pop -> one enable cycle -> HOLD cycles with value frozen.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= ST_IDLE;
            hcnt_r   <= 4'd0;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            value_r  <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        value_r  <= mem_r[rd_ptr_r];
                        state_r  <= ST_ISSUE;
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r  <= ST_HOLD;
                    hcnt_r   <= HCNT_INIT;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b1;
                end
                ST_HOLD: begin
                    if (hcnt_r != 4'd0) begin
                        hcnt_r   <= hcnt_r - 4'd1;
                        enable_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end else if (pop_s) begin
                        value_r  <= mem_r[rd_ptr_r];
                        state_r  <= ST_ISSUE;
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    hcnt_r   <= 4'd0;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready_s;
    assign enable   = enable_r;
    assign value    = value_r;
    assign busy     = busy_r;
    assign level    = level_r;

endmodule

// File: tb/tb_value_feeder.sv
// Directed bench for value_feeder: reset, single word, back-to-back, full/wrap,
// flush during HOLD and reset during HOLD, each against hand-computed expectations.
module tb_value_feeder;

    localparam int DW   = 32;
    localparam int AW   = 2;
    localparam int HOLD = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          in_ready;
    logic          enable;
    logic [DW-1:0] value;
    logic          busy;
    logic [AW:0]   level;

    int checks   = 0;
    int failures = 0;

    value_feeder #(.DW(DW), .AW(AW), .HOLD(HOLD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .enable   (enable),
        .value    (value),
        .busy     (busy),
        .level    (level)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] b2b [3]   = '{32'd5, 32'd7, 32'd9};
    logic [DW-1:0] words [8] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                                 32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};
    logic [DW-1:0] fw [4]    = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    logic [DW-1:0] got [$];
    logic [63:0]   sum;
    int            idx;
    logic          saw_full;
    logic          prev_en;

    initial begin
        // Reset held with in_valid asserted
        RST = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        chk("rst_enable", enable, 0);
        chk("rst_value", value, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        RST = 1'b1; in_valid = 1'b0;
        #1;
        chk("ready_after_release", in_ready, 1);

        // Single word: push in cycle c, enable in c+2, value held c+2..c+4
        tick();
        in_valid = 1'b1; in_data = 32'd5;
        #1;
        chk("single_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("single_level", level, 1);
        chk("single_en_c1", enable, 0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("single_en", enable, (k == 2) ? 64'd1 : 64'd0);
            chk("single_value", value, 64'd5);
            chk("single_busy", busy, (k <= 4) ? 64'd1 : 64'd0);
        end

        // Back-to-back 5,7,9
        sum = 64'd0;
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k < 3) begin
                in_valid = 1'b1; in_data = b2b[k];
            end else begin
                in_valid = 1'b0;
            end
            if (enable) sum = sum + 64'(value);
            if (k >= 2) begin
                chk("b2b_en", enable, (k == 2 || k == 5 || k == 8) ? 64'd1 : 64'd0);
                chk("b2b_value", value, (k < 5) ? 64'd5 : (k < 8) ? 64'd7 : 64'd9);
                chk("b2b_busy", busy, (k <= 10) ? 64'd1 : 64'd0);
            end
        end
        chk("b2b_sum", sum, 64'd21);

        // Full and wrap: offer 8 words as fast as accepted
        idx = 0; saw_full = 1'b0; prev_en = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (enable) got.push_back(value);
            chk("en_gap", {63'd0, prev_en & enable}, 0);
            prev_en = enable;
            if (idx < 8) begin
                in_valid = 1'b1; in_data = words[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (level == 3'd4) begin
                chk("full_ready", in_ready, 0);
                saw_full = 1'b1;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        chk("full_seen", saw_full, 1);
        chk("full_pushed", idx, 8);
        chk("full_issued", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_order", (i < got.size()) ? got[i] : 32'hX, words[i]);
        end

        // Flush during the first word's HOLD
        for (int k = 0; k <= 8; k++) begin
            tick();
            in_valid = (k < 4);
            in_data  = (k < 4) ? fw[k] : 32'd0;
            flush    = (k == 3);
            #1;
            if (k == 2) begin
                chk("flush_en_issue", enable, 1);
                chk("flush_val_c2", value, fw[0]);
            end
            if (k == 3) begin
                chk("flush_ready", in_ready, 0);
                chk("flush_busy_c3", busy, 1);
                chk("flush_val_c3", value, fw[0]);
            end
            if (k == 4) begin
                chk("flush_level", level, 0);
                chk("flush_val_c4", value, fw[0]);
                chk("flush_busy_c4", busy, 1);
                chk("flush_en_c4", enable, 0);
            end
            if (k >= 5) begin
                chk("flush_no_en", enable, 0);
                chk("flush_idle", busy, 0);
                chk("flush_level_after", level, 0);
            end
        end
        flush = 1'b0; in_valid = 1'b0;

        // Reset during HOLD with a second word still queued
        for (int k = 0; k <= 3; k++) begin
            tick();
            in_valid = (k < 2);
            in_data  = (k == 0) ? 32'hC0DE_0001 : 32'hC0DE_0002;
            if (k == 2) begin
                chk("mid_en", enable, 1);
                chk("mid_value", value, 64'hC0DE_0001);
            end
        end
        RST = 1'b0;
        #1;
        chk("mid_rst_value", value, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_enable", enable, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ready", in_ready, 0);
        tick();
        tick();
        RST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_en", enable, 0);
            chk("post_rst_level", level, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/value_feeder.md
# value_feeder

Upstream pacing stage for the accumulator FSM that drives the LED display. It accepts 32-bit words over a valid/ready stream, buffers them in a small FIFO, and presents each word on `value` with a one-cycle `enable` pulse. `value` is held stable for the accumulator's full three-cycle acceptance window (IDLE→1→2), so every buffered word is added exactly once and none is lost.

## Interface
- `DW`, default 32: data width; must match the accumulator's `value` width.
- `AW`, default 2: FIFO address width; depth = 2^AW entries.
- `HOLD`, default 2: cycles `value` is held after the `enable` cycle. Must be ≥2 for the accumulator; legal range 1..15.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert is guaranteed by the SoC reset logic.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  DW  upstream word.
- `in_ready`  out  1  FIFO can accept a word.
- `flush`  in  1  synchronous FIFO clear.
- `enable`  out  1  one-cycle issue pulse to the accumulator.
- `value`  out  DW  word to be accumulated; registered.
- `busy`  out  1  an issued word is still inside its hold window.
- `level`  out  AW+1  FIFO occupancy, 0..2^AW.

## Operation
- FIFO: a push occurs when `in_valid && in_ready`. `in_ready = RST && !flush && (level != 2^AW)`. When the FIFO is full, `in_ready` is 0 even if a pop occurs in the same cycle. Read and write pointers are AW bits and wrap modulo 2^AW. `level` is a separate counter: +1 on push, −1 on pop, unchanged on push+pop.
- FSM states and transitions:
  - IDLE: if `level > 0`, pop the head into the `value` register and go to ISSUE.
  - ISSUE: `enable = 1` for exactly this one cycle. Go to HOLD with `hcnt = HOLD-1`.
  - HOLD: `enable = 0`. If `hcnt != 0`, decrement `hcnt`. If `hcnt == 0` and `level > 0`, pop the next word and go to ISSUE (back-to-back issue). If `hcnt == 0` and `level == 0`, go to IDLE.
- `value` changes only on a pop. Between words it retains the last issued word.
- `busy = (state != IDLE)`.
- `flush`:
  - Sets `level`, `rd_ptr` and `wr_ptr` to 0 at the next edge.
  - Any push in the same cycle is blocked because `in_ready` is 0.
  - A pop in the same cycle is suppressed.
  - A word already in ISSUE or HOLD completes its hold window unchanged. Its accumulation is never aborted.
- Reset (asynchronous, any time, including mid-HOLD):
  - state = IDLE, `enable` = 0, `value` = 0, `level` = 0, pointers = 0, `hcnt` = 0.
  - `busy` = 0 and `in_ready` = 0 while `RST` is 0.
  - The partially held word is discarded. The accumulator shares the reset, so this is consistent.
- Arithmetic: none on the data path. Words pass through bit-exact.

## Timing
- Latency: a word pushed in cycle c into an empty FIFO with the FSM in IDLE is popped in cycle c+1, and `enable` is high in cycle c+2 with `value` equal to that word.
- `value` is stable from the `enable` cycle through the following HOLD cycles, i.e. cycles c+2..c+2+HOLD.
- Throughput: one word every HOLD+1 cycles (3 at the default). Consecutive `enable` pulses are exactly HOLD+1 cycles apart while the FIFO is non-empty.
- `enable` is never high in two consecutive cycles.
- `level` reflects pushes and pops one cycle after the handshake edge.
- First `in_ready = 1` appears in the first cycle after `RST` rises.

## Test plan
- Reset: hold `RST` = 0 for 3 cycles with `in_valid` = 1 → `enable` = 0, `value` = 0, `level` = 0, `in_ready` = 0, `busy` = 0. Release → `in_ready` = 1 next cycle.
- Single word: push 0x0000_0005 in cycle 10 → `enable` is high only in cycle 12, `value` = 5 in cycles 12–14, `busy` = 1 in cycles 12–14. Connected to the accumulator, `count` = 5.
- Back-to-back: push 5, 7, 9 in consecutive cycles → `enable` pulses 3 cycles apart with values 5, 7, 9. Accumulator `count` = 21 and `led` = 0x00.
- Full and wrap: with AW=2, push 8 words while issuing → `in_ready` drops when `level` = 4 and no word is lost. Issue order equals push order across pointer wrap.
- Flush mid-operation: queue 4 words, assert `flush` during the first word's HOLD → the first word still completes its 3-cycle window, `level` = 0 next cycle, and no further `enable` is issued.
- Reset mid-HOLD: pull `RST` low during the cycle after `enable` → `value` = 0 and `busy` = 0 asynchronously. After release, the FIFO is empty and `enable` stays 0.
